regfile_write_arbiter: RTL and testbench

// Arbitrates the single register-file write port between the in-order WB stage and a

---
 rtl/regfile_write_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//
// Shares the single register-file write port between the in-order WB stage
// and a long-latency return unit (non-blocking loads, iterative units).
//
// WB wins the port by default. Return-unit writes wait in a small FIFO and
// drain in cycles where WB does not write. If WB keeps winning for
// STARVE_LIMIT cycles while the FIFO is non-empty, WB is stalled for one
// cycle so the FIFO head can drain.
//
// A WB write cancels the matching bytes of older queued writes to the same
// register (WAW). Queued data is never forwarded, so ID asks whether its
// source register has a live queued write and stalls if it does.
//
// Optional feature (macro REGFILE_ARB_PERF_EN):
//   defined   -> adds perf_stall_count / perf_queue_full_count outputs
//   undefined -> those ports and counters are absent
//
// Parameters
//   FIFO_DEPTH    return-unit queue entries (power of two, >= 2)
//   STARVE_LIMIT  consecutive WB-won cycles with a non-empty FIFO before WB stalls
//
// Ports
//   clock, reset                    core clock, synchronous active-high reset
//   wb_write_enabled/_address/_strobe/_data   WB write request
//   wb_stall                        holds WB (ready_go low); registered state only
//   ret_valid/_address/_strobe/_data          return-unit write request
//   ret_ready                       FIFO not full
//   rf_write_enabled/_address/_strobe/_data   granted write, same cycle
//   rf_write_from_ret               granted slot came from the FIFO
//   id_query_address                ID source register to check
//   id_query_pending                a live queued write targets that register
//   perf_stall_count                cycles with wb_stall=1 (perf build only)
//   perf_queue_full_count           cycles with ret_ready=0 (perf build only)

module regfile_write_arbiter #(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clock,
    input  logic        reset,
`ifdef REGFILE_ARB_PERF_EN
    output logic [31:0] perf_stall_count,
    output logic [31:0] perf_queue_full_count,
`endif
    input  logic        wb_write_enabled,
    input  logic [4:0]  wb_write_address,
    input  logic [3:0]  wb_write_strobe,
    input  logic [31:0] wb_write_data,
    output logic        wb_stall,
    input  logic        ret_valid,
    output logic        ret_ready,
    input  logic [4:0]  ret_address,
    input  logic [3:0]  ret_strobe,
    input  logic [31:0] ret_data,
    output logic        rf_write_enabled,
    output logic [4:0]  rf_write_address,
    output logic [3:0]  rf_write_strobe,
    output logic [31:0] rf_write_data,
    output logic        rf_write_from_ret,
    input  logic [4:0]  id_query_address,
    output logic        id_query_pending
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [SC_W-1:0]  SC_LIMIT   = SC_W'(STARVE_LIMIT);

    // Saturating increment: the forced drain normally clears the counter at
    // the limit, the saturation only keeps it from ever wrapping.
    function automatic logic [SC_W-1:0] starve_sat_inc(input logic [SC_W-1:0] cnt);
        if (cnt == SC_LIMIT)
            return cnt;
        return cnt + SC_W'(1);
    endfunction

    // FIFO storage (data path, not reset) and control state
    logic [4:0]       q_addr [FIFO_DEPTH];
    logic [3:0]       q_strb [FIFO_DEPTH];
    logic [31:0]      q_data [FIFO_DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [SC_W-1:0]  starve_cnt;

    logic [FIFO_DEPTH-1:0] live;
    logic             fifo_empty;
    logic             force_drain;
    logic             grant_wb;
    logic             pop;
    logic             push_accept;
    logic             enq;

    // An entry is live when its distance from the read pointer (mod depth)
    // is below the occupancy count.
    always_comb begin
        live = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            live[i] = CNT_W'(PTR_W'(PTR_W'(i) - rd_ptr)) < count;
        end
    end

    // Grant decision uses only registered state plus wb_write_enabled;
    // wb_stall itself never looks at the wb_* inputs.
    assign fifo_empty  = (count == '0);
    assign force_drain = !fifo_empty && (starve_cnt == SC_LIMIT);
    assign grant_wb    = wb_write_enabled && !force_drain;
    assign pop         = !fifo_empty && !grant_wb;

    assign wb_stall    = force_drain;
    assign ret_ready   = (count != FULL_COUNT);

    // Writes to r0 or with an empty strobe are accepted but never stored.
    assign push_accept = ret_valid && ret_ready;
    assign enq         = push_accept && (ret_address != 5'd0) && (ret_strobe != 4'd0);

    always_comb begin
        rf_write_enabled  = 1'b0;
        rf_write_address  = '0;
        rf_write_strobe   = '0;
        rf_write_data     = '0;
        rf_write_from_ret = 1'b0;
        if (grant_wb) begin
            rf_write_enabled = 1'b1;
            rf_write_address = wb_write_address;
            rf_write_strobe  = wb_write_strobe;
            rf_write_data    = wb_write_data;
        end else if (pop) begin
            // A fully cancelled entry still uses its slot but writes nothing.
            rf_write_enabled  = (q_strb[rd_ptr] != 4'd0);
            rf_write_address  = q_addr[rd_ptr];
            rf_write_strobe   = q_strb[rd_ptr];
            rf_write_data     = q_data[rd_ptr];
            rf_write_from_ret = 1'b1;
        end
    end

    always_comb begin
        id_query_pending = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (live[i] && (q_addr[i] == id_query_address) && (q_strb[i] != 4'd0))
                id_query_pending = 1'b1;
        end
        if (id_query_address == 5'd0)
            id_query_pending = 1'b0;
    end

    // Control state: pointers, occupancy, starvation counter
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
        end else begin
            if (enq)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(enq) - CNT_W'(pop);

            if (fifo_empty || !grant_wb)
                starve_cnt <= '0;
            else
                starve_cnt <= starve_sat_inc(starve_cnt);
        end
    end

    // Entry storage: new push, or WAW byte cancel on older live entries.
    // The slot being pushed is never live (push needs count < depth), so a
    // same-cycle push is not masked by the WB write it is younger than.
    always_ff @(posedge clock) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (enq && (wr_ptr == PTR_W'(i))) begin
                q_addr[i] <= ret_address;
                q_strb[i] <= ret_strobe;
                q_data[i] <= ret_data;
            end else if (grant_wb && live[i] && (q_addr[i] == wb_write_address)) begin
                q_strb[i] <= q_strb[i] & ~wb_write_strobe;
            end
        end
    end

`ifdef REGFILE_ARB_PERF_EN
    // Free-running wrapping event counters
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_stall_count      <= '0;
            perf_queue_full_count <= '0;
        end else begin
            if (wb_stall)
                perf_stall_count <= perf_stall_count + 32'd1;
            if (!ret_ready)
                perf_queue_full_count <= perf_queue_full_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    localparam int FIFO_DEPTH   = 4;
    localparam int STARVE_LIMIT = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        wb_write_enabled;
    logic [4:0]  wb_write_address;
    logic [3:0]  wb_write_strobe;
    logic [31:0] wb_write_data;
    logic        wb_stall;
    logic        ret_valid;
    logic        ret_ready;
    logic [4:0]  ret_address;
    logic [3:0]  ret_strobe;
    logic [31:0] ret_data;
    logic        rf_write_enabled;
    logic [4:0]  rf_write_address;
    logic [3:0]  rf_write_strobe;
    logic [31:0] rf_write_data;
    logic        rf_write_from_ret;
    logic [4:0]  id_query_address;
    logic        id_query_pending;
`ifdef REGFILE_ARB_PERF_EN
    logic [31:0] perf_stall_count;
    logic [31:0] perf_queue_full_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    regfile_write_arbiter #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clock            (clock),
        .reset            (reset),
`ifdef REGFILE_ARB_PERF_EN
        .perf_stall_count     (perf_stall_count),
        .perf_queue_full_count(perf_queue_full_count),
`endif
        .wb_write_enabled (wb_write_enabled),
        .wb_write_address (wb_write_address),
        .wb_write_strobe  (wb_write_strobe),
        .wb_write_data    (wb_write_data),
        .wb_stall         (wb_stall),
        .ret_valid        (ret_valid),
        .ret_ready        (ret_ready),
        .ret_address      (ret_address),
        .ret_strobe       (ret_strobe),
        .ret_data         (ret_data),
        .rf_write_enabled (rf_write_enabled),
        .rf_write_address (rf_write_address),
        .rf_write_strobe  (rf_write_strobe),
        .rf_write_data    (rf_write_data),
        .rf_write_from_ret(rf_write_from_ret),
        .id_query_address (id_query_address),
        .id_query_pending (id_query_pending)
    );

    // Behavioural reference: a queue of pending writes plus a run length of
    // WB wins while something is waiting.
    typedef struct {
        logic [4:0]  a;
        logic [3:0]  s;
        logic [31:0] d;
    } ent_t;

    ent_t mq[$];
    int   m_starve = 0;

    logic        exp_stall, exp_ready, exp_en, exp_from_ret, exp_pending;
    logic [4:0]  exp_addr;
    logic [3:0]  exp_strb;
    logic [31:0] exp_data;
    logic        m_wb, m_pop;

    function void model_eval();
        exp_stall = 1'b0; exp_en = 1'b0; exp_from_ret = 1'b0;
        exp_addr = '0; exp_strb = '0; exp_data = '0;
        m_wb = 1'b0; m_pop = 1'b0;
        if (mq.size() == 0) begin
            m_wb = wb_write_enabled;
        end else if (m_starve == STARVE_LIMIT) begin
            exp_stall = 1'b1;
            m_pop = 1'b1;
        end else if (wb_write_enabled) begin
            m_wb = 1'b1;
        end else begin
            m_pop = 1'b1;
        end
        if (m_wb) begin
            exp_en = 1'b1; exp_addr = wb_write_address;
            exp_strb = wb_write_strobe; exp_data = wb_write_data;
        end else if (m_pop) begin
            exp_en = (mq[0].s != 0); exp_addr = mq[0].a;
            exp_strb = mq[0].s; exp_data = mq[0].d; exp_from_ret = 1'b1;
        end
        exp_ready = (mq.size() < FIFO_DEPTH);
        exp_pending = 1'b0;
        foreach (mq[i])
            if (id_query_address != 0 && mq[i].a == id_query_address && mq[i].s != 0)
                exp_pending = 1'b1;
    endfunction

    function void model_commit();
        ent_t e;
        if (reset) begin
            mq.delete();
            m_starve = 0;
            return;
        end
        if (m_wb && mq.size() != 0) m_starve = m_starve + 1;
        else m_starve = 0;
        if (m_starve > STARVE_LIMIT) m_starve = STARVE_LIMIT;
        if (m_wb)
            foreach (mq[i])
                if (mq[i].a == wb_write_address) mq[i].s = mq[i].s & ~wb_write_strobe;
        if (m_pop) void'(mq.pop_front());
        if (ret_valid && exp_ready && ret_address != 0 && ret_strobe != 0) begin
            e.a = ret_address; e.s = ret_strobe; e.d = ret_data;
            mq.push_back(e);
        end
    endfunction

    // Advance one clock: model sees the inputs held at the edge.
    task tick();
        model_eval();
        @(posedge clock);
        model_commit();
        @(negedge clock);
    endtask

    task set_idle();
        wb_write_enabled = 0; wb_write_address = 0; wb_write_strobe = 0; wb_write_data = 0;
        ret_valid = 0; ret_address = 0; ret_strobe = 0; ret_data = 0;
        id_query_address = 0;
    endtask

    task do_reset();
        set_idle();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task test_reset();
        set_idle();
        reset = 1;
        tick();
        tick();
        id_query_address = 5'd7;
        #1;
        checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b want=0", wb_stall); end
        checks++; if (ret_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", ret_ready); end
        checks++; if (rf_write_enabled !== 1'b0) begin errors++; $display("FAIL reset_rf_en got=%b want=0", rf_write_enabled); end
        checks++; if (id_query_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got=%b want=0", id_query_pending); end
        reset = 0;
        tick();
    endtask

    task test_wb_direct();
        do_reset();
        wb_write_enabled = 1; wb_write_address = 5'd5; wb_write_strobe = 4'hF; wb_write_data = 32'h11223344;
        #1;
        checks++; if (rf_write_enabled !== 1'b1 || rf_write_address !== 5'd5)
            begin errors++; $display("FAIL wb_direct_addr got en=%b a=%0d want en=1 a=5", rf_write_enabled, rf_write_address); end
        checks++; if (rf_write_data !== 32'h11223344 || rf_write_strobe !== 4'hF)
            begin errors++; $display("FAIL wb_direct_data got %h/%h want 11223344/f", rf_write_data, rf_write_strobe); end
        checks++; if (rf_write_from_ret !== 1'b0 || wb_stall !== 1'b0)
            begin errors++; $display("FAIL wb_direct_src got from_ret=%b stall=%b want 0/0", rf_write_from_ret, wb_stall); end
        tick();
        set_idle();
    endtask

    task test_ret_drain();
        do_reset();
        ret_valid = 1; ret_address = 5'd7; ret_strobe = 4'hF; ret_data = 32'hAABBCCDD;
        #1;
        checks++; if (rf_write_enabled !== 1'b0) begin errors++; $display("FAIL ret_push_rf got=%b want=0", rf_write_enabled); end
        tick();
        set_idle();
        id_query_address = 5'd7;
        #1;
        checks++; if (id_query_pending !== 1'b1) begin errors++; $display("FAIL ret_pending_live got=%b want=1", id_query_pending); end
        checks++; if (rf_write_enabled !== 1'b1 || rf_write_address !== 5'd7 || rf_write_data !== 32'hAABBCCDD || rf_write_from_ret !== 1'b1)
            begin errors++; $display("FAIL ret_drain got en=%b a=%0d d=%h fr=%b want 1/7/aabbccdd/1",
                rf_write_enabled, rf_write_address, rf_write_data, rf_write_from_ret); end
        tick();
        #1;
        checks++; if (id_query_pending !== 1'b0) begin errors++; $display("FAIL ret_pending_after got=%b want=0", id_query_pending); end
        checks++; if (rf_write_enabled !== 1'b0) begin errors++; $display("FAIL ret_empty_rf got=%b want=0", rf_write_enabled); end
        set_idle();
    endtask

    task test_starvation();
        do_reset();
        wb_write_enabled = 1; wb_write_address = 5'd1; wb_write_strobe = 4'hF; wb_write_data = 32'h1;
        ret_valid = 1; ret_address = 5'd9; ret_strobe = 4'hF; ret_data = 32'h99;
        tick();
        ret_valid = 0;
        for (int k = 0; k < STARVE_LIMIT; k++) begin
            wb_write_address = 5'd2; wb_write_data = 32'(k);
            #1;
            checks++; if (wb_stall !== 1'b0 || rf_write_enabled !== 1'b1 || rf_write_from_ret !== 1'b0)
                begin errors++; $display("FAIL starve_wb_grant%0d got stall=%b en=%b fr=%b want 0/1/0", k, wb_stall, rf_write_enabled, rf_write_from_ret); end
            tick();
        end
        #1;
        checks++; if (wb_stall !== 1'b1) begin errors++; $display("FAIL starve_stall got=%b want=1", wb_stall); end
        checks++; if (rf_write_enabled !== 1'b1 || rf_write_address !== 5'd9 || rf_write_data !== 32'h99 || rf_write_from_ret !== 1'b1)
            begin errors++; $display("FAIL starve_drain got en=%b a=%0d d=%h fr=%b want 1/9/99/1",
                rf_write_enabled, rf_write_address, rf_write_data, rf_write_from_ret); end
        tick();
        #1;
        checks++; if (wb_stall !== 1'b0 || rf_write_from_ret !== 1'b0)
            begin errors++; $display("FAIL starve_release got stall=%b fr=%b want 0/0", wb_stall, rf_write_from_ret); end
        tick();
        set_idle();
    endtask

    task test_waw_cancel();
        // Partial cancel
        do_reset();
        wb_write_enabled = 1; wb_write_address = 5'd10; wb_write_strobe = 4'hF;
        ret_valid = 1; ret_address = 5'd3; ret_strobe = 4'hF; ret_data = 32'h12345678;
        tick();
        ret_valid = 0;
        wb_write_address = 5'd3; wb_write_strobe = 4'b0011;
        tick();
        set_idle();
        #1;
        checks++; if (rf_write_enabled !== 1'b1 || rf_write_address !== 5'd3 || rf_write_strobe !== 4'b1100 || rf_write_data !== 32'h12345678)
            begin errors++; $display("FAIL waw_partial got en=%b a=%0d s=%b d=%h want 1/3/1100/12345678",
                rf_write_enabled, rf_write_address, rf_write_strobe, rf_write_data); end
        tick();
        // Full cancel: slot consumed with no write
        wb_write_enabled = 1; wb_write_address = 5'd10; wb_write_strobe = 4'hF;
        ret_valid = 1; ret_address = 5'd3; ret_strobe = 4'hF; ret_data = 32'h55;
        tick();
        ret_valid = 0;
        wb_write_address = 5'd3; wb_write_strobe = 4'hF;
        tick();
        set_idle();
        id_query_address = 5'd3;
        #1;
        checks++; if (rf_write_enabled !== 1'b0) begin errors++; $display("FAIL waw_full_rf got=%b want=0", rf_write_enabled); end
        checks++; if (id_query_pending !== 1'b0) begin errors++; $display("FAIL waw_full_pending got=%b want=0", id_query_pending); end
        tick();
        // Same-cycle push is younger than the WB write and keeps its bytes
        wb_write_enabled = 1; wb_write_address = 5'd4; wb_write_strobe = 4'hF;
        ret_valid = 1; ret_address = 5'd4; ret_strobe = 4'hF; ret_data = 32'h44;
        tick();
        set_idle();
        #1;
        checks++; if (rf_write_enabled !== 1'b1 || rf_write_address !== 5'd4 || rf_write_strobe !== 4'hF)
            begin errors++; $display("FAIL waw_young got en=%b a=%0d s=%b want 1/4/1111", rf_write_enabled, rf_write_address, rf_write_strobe); end
        tick();
    endtask

    task test_full_and_r0();
        do_reset();
        wb_write_enabled = 1; wb_write_address = 5'd1; wb_write_strobe = 4'hF;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            ret_valid = 1; ret_address = 5'(11 + k); ret_strobe = 4'hF; ret_data = 32'(k + 100);
            tick();
        end
        ret_valid = 0;
        id_query_address = 5'd0;
        #1;
        checks++; if (ret_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b want=0", ret_ready); end
        checks++; if (id_query_pending !== 1'b0) begin errors++; $display("FAIL full_pending_r0 got=%b want=0", id_query_pending); end
        id_query_address = 5'd12;
        #1;
        checks++; if (id_query_pending !== 1'b1) begin errors++; $display("FAIL full_pending_r12 got=%b want=1", id_query_pending); end
        // Pop while full: no bypass, the offered push must be refused
        wb_write_enabled = 0;
        ret_valid = 1; ret_address = 5'd20; ret_strobe = 4'hF; ret_data = 32'hDEAD;
        #1;
        checks++; if (ret_ready !== 1'b0) begin errors++; $display("FAIL full_pop_ready got=%b want=0", ret_ready); end
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            #1;
            checks++; if (rf_write_enabled !== 1'b1 || rf_write_address !== 5'(11 + k) || rf_write_data !== 32'(k + 100))
                begin errors++; $display("FAIL full_drain%0d got en=%b a=%0d d=%h want 1/%0d/%h",
                    k, rf_write_enabled, rf_write_address, rf_write_data, 11 + k, k + 100); end
            tick();
            ret_valid = 0;
        end
        // Writes to r0 and empty-strobe writes are accepted and dropped
        ret_valid = 1; ret_address = 5'd0; ret_strobe = 4'hF;
        #1;
        checks++; if (rf_write_enabled !== 1'b0 || ret_ready !== 1'b1)
            begin errors++; $display("FAIL full_refused got en=%b rdy=%b want 0/1", rf_write_enabled, ret_ready); end
        tick();
        ret_address = 5'd6; ret_strobe = 4'h0;
        tick();
        set_idle();
        id_query_address = 5'd6;
        #1;
        checks++; if (rf_write_enabled !== 1'b0 || id_query_pending !== 1'b0)
            begin errors++; $display("FAIL drop_r0_strb0 got en=%b pend=%b want 0/0", rf_write_enabled, id_query_pending); end
        tick();
    endtask

    task test_reset_mid_queue();
        do_reset();
        wb_write_enabled = 1; wb_write_address = 5'd1; wb_write_strobe = 4'hF;
        for (int k = 0; k < 3; k++) begin
            ret_valid = 1; ret_address = 5'(21 + k); ret_strobe = 4'hF; ret_data = 32'(k);
            tick();
        end
        set_idle();
        reset = 1;
        tick();
        reset = 0;
        id_query_address = 5'd22;
        #1;
        checks++; if (ret_ready !== 1'b1 || id_query_pending !== 1'b0)
            begin errors++; $display("FAIL rst_mid got rdy=%b pend=%b want 1/0", ret_ready, id_query_pending); end
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (rf_write_enabled !== 1'b0) begin errors++; $display("FAIL rst_mid_rf%0d got=%b want=0", k, rf_write_enabled); end
            tick();
        end
    endtask

    task test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            wb_write_enabled = ($urandom_range(0, 99) < 70);
            wb_write_address = 5'($urandom_range(0, 7));
            wb_write_strobe  = 4'($urandom);
            wb_write_data    = $urandom;
            ret_valid        = ($urandom_range(0, 99) < 50);
            ret_address      = 5'($urandom_range(0, 7));
            ret_strobe       = 4'($urandom);
            ret_data         = $urandom;
            id_query_address = 5'($urandom_range(0, 7));
            #1;
            model_eval();
            checks++; if (wb_stall !== exp_stall || ret_ready !== exp_ready || rf_write_enabled !== exp_en || id_query_pending !== exp_pending)
                begin errors++; $display("FAIL rand_ctrl c=%0d got st=%b rdy=%b en=%b pend=%b want %b/%b/%b/%b", c,
                    wb_stall, ret_ready, rf_write_enabled, id_query_pending, exp_stall, exp_ready, exp_en, exp_pending); end
            if (exp_en) begin
                checks++; if (rf_write_address !== exp_addr || rf_write_strobe !== exp_strb || rf_write_data !== exp_data || rf_write_from_ret !== exp_from_ret)
                    begin errors++; $display("FAIL rand_write c=%0d got a=%0d s=%b d=%h fr=%b want a=%0d s=%b d=%h fr=%b", c,
                        rf_write_address, rf_write_strobe, rf_write_data, rf_write_from_ret, exp_addr, exp_strb, exp_data, exp_from_ret); end
            end
            tick();
        end
        set_idle();
    endtask

    initial begin
        reset = 1;
        set_idle();
        @(negedge clock);
        test_reset();
        test_wb_direct();
        test_ret_drain();
        test_starvation();
        test_waw_cancel();
        test_full_and_r0();
        test_reset_mid_queue();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
